fifo_write_scheduler: RTL and testbench
=======================================

// Module: fifo_write_scheduler
// PURPOSE
//  Shares the single FIFO write port between two byte producers: req0 = UART rx path, req1 = push-button value generator.
//  Arbitration is round-robin. Writes are sequenced against FIFO busy/full.
//  The block also starts the FIFO->out->com drain when the fill level reaches a threshold, the FIFO is full, or a terminator byte is written.
//  Sits between the producers and FIFO/FIFO_to_out; replaces ad-hoc per-test upload FSMs.
// PARAMETERS
//  DATA_W       8      byte width of producer data and fifo_din
//  CNT_W        10     width of fifo_count (matches FIFO depth counter)
//  DRAIN_LEVEL  16     fifo_count >= this (checked in IDLE) starts a drain
//  TERM_BYTE    8'h0D  writing this byte arms a drain at next IDLE
// PORTS
//  clk          in   1       single clock, all logic posedge
//  reset        in   1       asynchronous, active-high
//  req0         in   1       producer 0 request, level, held until ack0
//  data0        in   DATA_W  producer 0 byte, stable while req0=1
//  ack0         out  1       1-cycle pulse: data0 written to FIFO
//  req1         in   1       producer 1 request, level, held until ack1
//  data1        in   DATA_W  producer 1 byte, stable while req1=1
//  ack1         out  1       1-cycle pulse: data1 written to FIFO
//  fifo_busy    in   1       FIFO busy; no write may issue while 1
//  fifo_full    in   1       FIFO full
//  fifo_count   in   CNT_W   FIFO occupancy
//  fifo_we      out  1       FIFO write enable, exactly 1 cycle per byte
//  fifo_din     out  DATA_W  byte to FIFO, valid with fifo_we
//  drain_en     out  1       enables FIFO_to_out + Out_to_com
//  drain_done   in   1       1-cycle pulse: drain finished, FIFO empty
//  wr_total     out  16      count of bytes written, wraps at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE; ack0/ack1/fifo_we/drain_en=0; fifo_din=0; wr_total=0; term_flag=0; pending=0; last_grant=1 (req0 wins first).
//    Reset mid-operation aborts any write/drain at once; no ack is issued.
//  All outputs are registered. States:
//  IDLE:
//    - If term_flag | fifo_full | fifo_count>=DRAIN_LEVEL: go to DRAIN.
//    - Else if any req: grant via round-robin. Sole requester wins; with both, the one != last_grant wins.
//      Latch its data into fifo_din, record grant, go to SETUP.
//  SETUP:
//    - fifo_full=1: set pending=1, go to DRAIN. The grant and fifo_din are kept; the byte is not dropped.
//    - Else if fifo_busy=0: go to WRITE.
//    - Else wait.
//  WRITE (1 cycle):
//    - fifo_we=1; ack of the granted requester =1.
//    - last_grant<=grant; wr_total++.
//    - If fifo_din==TERM_BYTE, term_flag<=1.
//    - Go to IDLE. fifo_we and ack drop the next cycle.
//  DRAIN:
//    - drain_en=1 until a drain_done pulse is seen.
//    - Then drain_en=0, term_flag<=0, and go to SETUP if pending (pending<=0), else IDLE.
//    - Requests during DRAIN wait; none are acked.
//  Latency: req rising in IDLE with FIFO idle -> fifo_we + ack 2 cycles later. Back-to-back throughput is 1 byte / 3 cycles.
//  A requester must drop req the cycle after ack. If req is still high in IDLE, it is treated as a new byte.
//  req0 and req1 rising together: req0 serviced first after reset, then strict alternation while both remain asserted.
//  drain_done outside DRAIN is ignored. fifo_busy is ignored outside SETUP.
//  Terminator write that also hits DRAIN_LEVEL: only one drain is started.
// STRUCTURE
//  Shared package/header: state encodings (IDLE, SETUP, WRITE, DRAIN) and the default TERM_BYTE constant.
//  Sub-module rr_arb2: 2-way round-robin, inputs req0/req1/last_grant, output grant + valid; combinational.
//  The FSM, fifo_din latch, term_flag/pending flags and wr_total stay in this module.
// TESTING
//  1. Reset, req1 with data1=8'h41, FIFO idle -> fifo_we 1 cycle with fifo_din=8'h41, ack1 same cycle, wr_total=1.
//  2. req0=8'h10 and req1=8'h20 rise together, held -> write order 10,20,10,20 with alternating acks.
//  3. fifo_busy high 5 cycles during SETUP -> no fifo_we until busy drops; fifo_we on the 1st cycle after busy low.
//  4. Write 8'h0D -> drain_en rises next IDLE; drain_done pulse -> drain_en=0, term_flag cleared; a new req is then written.
//  5. fifo_full asserted while req0 is in SETUP -> DRAIN with pending. After drain_done the same byte is written once with ack0; wr_total +1.
//  6. Assert reset mid-DRAIN and mid-WRITE -> drain_en/fifo_we/ack low at once; after release the first write goes to req0.

Source files
------------

// File: rtl/fifo_write_scheduler_pkg.sv
// Shared definitions for the FIFO write scheduler: FSM state encoding and
// the default terminator byte that arms a drain once it has been written.
package fifo_write_scheduler_pkg;

  // Scheduler states: wait for work, wait for FIFO ready, single write cycle, drain
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } sched_state_t;

  // Carriage return ends a message and triggers an upload of the FIFO
  localparam logic [7:0] DEFAULT_TERM_BYTE = 8'h0D;

  // Grant encoding used by the arbiter and the scheduler
  localparam logic GRANT_REQ0 = 1'b0;
  localparam logic GRANT_REQ1 = 1'b1;

endpackage

// File: rtl/fifo_write_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: a sole requester always
// wins, and when both request the one that was not served last wins.
module rr_arb2
  import fifo_write_scheduler_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_valid
);

  // Pick the winner; with both requesting, alternate away from the last grant
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = GRANT_REQ0;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last_grant;
    end else if (i_req1) begin
      o_grant = GRANT_REQ1;
    end
  end

endmodule

// File: rtl/fifo_write_scheduler.sv
// Shares the single FIFO write port between the UART rx path (req0) and the
// push-button value generator (req1), sequences each write against FIFO
// busy/full, and starts the FIFO->out->com drain on level, full or terminator.
module fifo_write_scheduler
  import fifo_write_scheduler_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                CNT_W       = 10,
  parameter int                DRAIN_LEVEL = 16,
  parameter logic [DATA_W-1:0] TERM_BYTE   = DATA_W'(DEFAULT_TERM_BYTE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  input  logic              fifo_busy,
  input  logic              fifo_full,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_din,
  output logic              drain_en,
  input  logic              drain_done,
  output logic [15:0]       wr_total
);

  sched_state_t      r_state;
  sched_state_t      w_next_state;

  logic              r_grant;
  logic              r_last_grant;
  logic              r_term_flag;
  logic              r_pending;
  logic [DATA_W-1:0] r_fifo_din;
  logic [15:0]       r_wr_total;
  logic              r_fifo_we;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_drain_en;

  logic              w_arb_grant;
  logic              w_arb_valid;
  logic              w_drain_trigger;
  logic              w_fifo_we_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;
  logic              w_drain_en_nxt;

  rr_arb2 u_arb (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_valid      (w_arb_valid)
  );

  // A drain is due when a terminator was written, the FIFO is full, or it is filled past the level
  assign w_drain_trigger = r_term_flag | fifo_full | (fifo_count >= CNT_W'(DRAIN_LEVEL));

  // State register; reset aborts any write or drain in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: drains take priority over new bytes while idle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_drain_trigger) begin
          w_next_state = ST_DRAIN;
        end else if (w_arb_valid) begin
          w_next_state = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (fifo_full) begin
          w_next_state = ST_DRAIN;
        end else if (!fifo_busy) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        if (drain_done) begin
          w_next_state = r_pending ? ST_SETUP : ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    w_fifo_we_nxt  = (w_next_state == ST_WRITE);
    w_ack0_nxt     = (w_next_state == ST_WRITE) && (r_grant == GRANT_REQ0);
    w_ack1_nxt     = (w_next_state == ST_WRITE) && (r_grant == GRANT_REQ1);
    w_drain_en_nxt = (w_next_state == ST_DRAIN);
  end

  // Output registers; cleared asynchronously so a reset drops them immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo_we  <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_drain_en <= 1'b0;
    end else begin
      r_fifo_we  <= w_fifo_we_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_drain_en <= w_drain_en_nxt;
    end
  end

  // Grant/data latch, flags and write counter; a byte held across a full-FIFO drain is kept intact
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant      <= GRANT_REQ0;
      r_last_grant <= GRANT_REQ1;
      r_term_flag  <= 1'b0;
      r_pending    <= 1'b0;
      r_fifo_din   <= '0;
      r_wr_total   <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_drain_trigger && w_arb_valid) begin
            r_grant    <= w_arb_grant;
            r_fifo_din <= (w_arb_grant == GRANT_REQ1) ? data1 : data0;
          end
        end
        ST_SETUP: begin
          if (fifo_full) begin
            r_pending <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_last_grant <= r_grant;
          r_wr_total   <= r_wr_total + 16'd1;
          if (r_fifo_din == TERM_BYTE) begin
            r_term_flag <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            r_term_flag <= 1'b0;
            r_pending   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fifo_we  = r_fifo_we;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign drain_en = r_drain_en;
  assign fifo_din = r_fifo_din;
  assign wr_total = r_wr_total;

endmodule

// File: tb/tb_fifo_write_scheduler.sv
// Directed testbench for fifo_write_scheduler: reset, single write, round-robin
// alternation, busy stalls, terminator drain, full-FIFO pending byte, drain
// level boundary and reset in the middle of a drain or write.
module tb_fifo_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1;
  logic        fifo_busy, fifo_full;
  logic [9:0]  fifo_count;
  logic        fifo_we;
  logic [7:0]  fifo_din;
  logic        drain_en;
  logic        drain_done;
  logic [15:0] wr_total;

  int checkCount = 0;
  int failCount  = 0;

  fifo_write_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .data0      (data0),
    .ack0       (ack0),
    .req1       (req1),
    .data1      (data1),
    .ack1       (ack1),
    .fifo_busy  (fifo_busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .fifo_we    (fifo_we),
    .fifo_din   (fifo_din),
    .drain_en   (drain_en),
    .drain_done (drain_done),
    .wr_total   (wr_total)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Advance until fifo_we is seen, returning the cycle count or -1 on timeout
  task automatic waitWrite(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      applyStimulus();
      if (fifo_we === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
    fifo_busy = 0; fifo_full = 0; fifo_count = 0; drain_done = 0;
    applyStimulus();
    applyStimulus();
    checkCount++; if (fifo_we !== 1'b0)    begin failCount++; $display("[TB] FAIL rst_we actual=%0b required=0", fifo_we); end
    checkCount++; if (ack0 !== 1'b0)       begin failCount++; $display("[TB] FAIL rst_ack0 actual=%0b required=0", ack0); end
    checkCount++; if (ack1 !== 1'b0)       begin failCount++; $display("[TB] FAIL rst_ack1 actual=%0b required=0", ack1); end
    checkCount++; if (drain_en !== 1'b0)   begin failCount++; $display("[TB] FAIL rst_drain actual=%0b required=0", drain_en); end
    checkCount++; if (fifo_din !== 8'h00)  begin failCount++; $display("[TB] FAIL rst_din actual=%h required=00", fifo_din); end
    checkCount++; if (wr_total !== 16'd0)  begin failCount++; $display("[TB] FAIL rst_total actual=%0d required=0", wr_total); end
    reset = 1'b0;
    applyStimulus();
  endtask

  task automatic test_single_write();
    int n;
    req1 = 1'b1; data1 = 8'h41;
    waitWrite(8, n);
    checkCount++; if (n != 2)             begin failCount++; $display("[TB] FAIL single_latency actual=%0d required=2", n); end
    checkCount++; if (fifo_din !== 8'h41) begin failCount++; $display("[TB] FAIL single_din actual=%h required=41", fifo_din); end
    checkCount++; if (ack1 !== 1'b1 || ack0 !== 1'b0) begin failCount++; $display("[TB] FAIL single_ack actual=%0b%0b required=10", ack1, ack0); end
    req1 = 1'b0;
    applyStimulus();
    checkCount++; if (fifo_we !== 1'b0 || ack1 !== 1'b0) begin failCount++; $display("[TB] FAIL single_pulse actual=%0b%0b required=00", fifo_we, ack1); end
    checkCount++; if (wr_total !== 16'd1) begin failCount++; $display("[TB] FAIL single_total actual=%0d required=1", wr_total); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [7:0] expDin;
    req0 = 1'b1; data0 = 8'h10;
    req1 = 1'b1; data1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      expDin = (i % 2 == 0) ? 8'h10 : 8'h20;
      waitWrite(8, n);
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      checkCount++; if (n != ((i == 0) ? 2 : 3)) begin failCount++; $display("[TB] FAIL rr_latency%0d actual=%0d required=%0d", i, n, (i == 0) ? 2 : 3); end
      checkCount++; if (fifo_din !== expDin)     begin failCount++; $display("[TB] FAIL rr_din%0d actual=%h required=%h", i, fifo_din, expDin); end
      checkCount++; if (ack0 !== (i % 2 == 0) || ack1 !== (i % 2 == 1)) begin failCount++; $display("[TB] FAIL rr_ack%0d actual=%0b%0b required=%0b%0b", i, ack0, ack1, (i % 2 == 0), (i % 2 == 1)); end
    end
    applyStimulus();
    checkCount++; if (wr_total !== 16'd5) begin failCount++; $display("[TB] FAIL rr_total actual=%0d required=5", wr_total); end
  endtask

  task automatic test_busy();
    int early;
    early = 0;
    fifo_busy = 1'b1;
    req0 = 1'b1; data0 = 8'h33;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (fifo_we !== 1'b0) early++;
    end
    checkCount++; if (early != 0) begin failCount++; $display("[TB] FAIL busy_stall actual=%0d required=0", early); end
    fifo_busy = 1'b0;
    applyStimulus();
    req0 = 1'b0;
    checkCount++; if (fifo_we !== 1'b1 || ack0 !== 1'b1) begin failCount++; $display("[TB] FAIL busy_release actual=%0b%0b required=11", fifo_we, ack0); end
    checkCount++; if (fifo_din !== 8'h33) begin failCount++; $display("[TB] FAIL busy_din actual=%h required=33", fifo_din); end
    applyStimulus();
    checkCount++; if (wr_total !== 16'd6) begin failCount++; $display("[TB] FAIL busy_total actual=%0d required=6", wr_total); end
  endtask

  task automatic test_terminator();
    int n, spurious;
    spurious = 0;
    req1 = 1'b1; data1 = 8'h0D;
    waitWrite(8, n);
    req1 = 1'b0;
    checkCount++; if (n != 2 || fifo_din !== 8'h0D || ack1 !== 1'b1) begin failCount++; $display("[TB] FAIL term_write actual=%0d/%h/%0b required=2/0d/1", n, fifo_din, ack1); end
    applyStimulus();
    checkCount++; if (drain_en !== 1'b0) begin failCount++; $display("[TB] FAIL term_idle actual=%0b required=0", drain_en); end
    applyStimulus();
    checkCount++; if (drain_en !== 1'b1) begin failCount++; $display("[TB] FAIL term_drain actual=%0b required=1", drain_en); end
    req0 = 1'b1; data0 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      if (ack0 !== 1'b0 || fifo_we !== 1'b0 || drain_en !== 1'b1) spurious++;
    end
    checkCount++; if (spurious != 0) begin failCount++; $display("[TB] FAIL term_hold actual=%0d required=0", spurious); end
    drain_done = 1'b1;
    applyStimulus();
    drain_done = 1'b0;
    checkCount++; if (drain_en !== 1'b0) begin failCount++; $display("[TB] FAIL term_done actual=%0b required=0", drain_en); end
    waitWrite(8, n);
    req0 = 1'b0;
    checkCount++; if (n != 2 || fifo_din !== 8'h55 || ack0 !== 1'b1) begin failCount++; $display("[TB] FAIL term_next actual=%0d/%h/%0b required=2/55/1", n, fifo_din, ack0); end
    applyStimulus();
    checkCount++; if (wr_total !== 16'd8) begin failCount++; $display("[TB] FAIL term_total actual=%0d required=8", wr_total); end
  endtask

  task automatic test_full_pending();
    int extra;
    extra = 0;
    req0 = 1'b1; data0 = 8'h77;
    applyStimulus();
    fifo_full = 1'b1;
    applyStimulus();
    checkCount++; if (drain_en !== 1'b1 || fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL full_drain actual=%0b%0b required=10", drain_en, fifo_we); end
    fifo_full = 1'b0;
    applyStimulus();
    applyStimulus();
    checkCount++; if (drain_en !== 1'b1 || ack0 !== 1'b0) begin failCount++; $display("[TB] FAIL full_hold actual=%0b%0b required=10", drain_en, ack0); end
    drain_done = 1'b1;
    applyStimulus();
    drain_done = 1'b0;
    checkCount++; if (drain_en !== 1'b0 || fifo_we !== 1'b0) begin failCount++; $display("[TB] FAIL full_setup actual=%0b%0b required=00", drain_en, fifo_we); end
    applyStimulus();
    req0 = 1'b0;
    checkCount++; if (fifo_we !== 1'b1 || ack0 !== 1'b1 || fifo_din !== 8'h77) begin failCount++; $display("[TB] FAIL full_write actual=%0b/%0b/%h required=1/1/77", fifo_we, ack0, fifo_din); end
    applyStimulus();
    checkCount++; if (wr_total !== 16'd9) begin failCount++; $display("[TB] FAIL full_total actual=%0d required=9", wr_total); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (fifo_we !== 1'b0) extra++;
    end
    checkCount++; if (extra != 0) begin failCount++; $display("[TB] FAIL full_once actual=%0d required=0", extra); end
  endtask

  task automatic test_drain_level();
    int n;
    fifo_count = 10'd15;
    req1 = 1'b1; data1 = 8'h22;
    waitWrite(8, n);
    req1 = 1'b0;
    checkCount++; if (n != 2 || fifo_din !== 8'h22) begin failCount++; $display("[TB] FAIL lvl15_write actual=%0d/%h required=2/22", n, fifo_din); end
    applyStimulus();
    applyStimulus();
    checkCount++; if (drain_en !== 1'b0) begin failCount++; $display("[TB] FAIL lvl15_nodrain actual=%0b required=0", drain_en); end
    fifo_count = 10'd16;
    applyStimulus();
    checkCount++; if (drain_en !== 1'b1) begin failCount++; $display("[TB] FAIL lvl16_drain actual=%0b required=1", drain_en); end
    fifo_count = 10'd0;
    drain_done = 1'b1;
    applyStimulus();
    drain_done = 1'b0;
    checkCount++; if (drain_en !== 1'b0 || wr_total !== 16'd10) begin failCount++; $display("[TB] FAIL lvl_done actual=%0b/%0d required=0/10", drain_en, wr_total); end
  endtask

  task automatic test_reset_mid_op();
    int n;
    fifo_count = 10'd16;
    applyStimulus();
    checkCount++; if (drain_en !== 1'b1) begin failCount++; $display("[TB] FAIL rmid_pre_drain actual=%0b required=1", drain_en); end
    reset = 1'b1;
    #1;
    checkCount++; if (drain_en !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_drain actual=%0b required=0", drain_en); end
    fifo_count = 10'd0;
    applyStimulus();
    reset = 1'b0;
    req1 = 1'b1; data1 = 8'h99;
    applyStimulus();
    applyStimulus();
    checkCount++; if (fifo_we !== 1'b1) begin failCount++; $display("[TB] FAIL rmid_pre_write actual=%0b required=1", fifo_we); end
    reset = 1'b1;
    #1;
    checkCount++; if (fifo_we !== 1'b0 || ack1 !== 1'b0 || wr_total !== 16'd0) begin failCount++; $display("[TB] FAIL rmid_write actual=%0b/%0b/%0d required=0/0/0", fifo_we, ack1, wr_total); end
    req1 = 1'b0;
    applyStimulus();
    reset = 1'b0;
    req0 = 1'b1; data0 = 8'hA0;
    req1 = 1'b1; data1 = 8'hB0;
    waitWrite(8, n);
    req0 = 1'b0; req1 = 1'b0;
    checkCount++; if (n != 2 || fifo_din !== 8'hA0 || ack0 !== 1'b1 || ack1 !== 1'b0) begin failCount++; $display("[TB] FAIL rmid_first actual=%0d/%h/%0b%0b required=2/a0/10", n, fifo_din, ack0, ack1); end
    applyStimulus();
    checkCount++; if (wr_total !== 16'd1) begin failCount++; $display("[TB] FAIL rmid_total actual=%0d required=1", wr_total); end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_busy();
    test_terminator();
    test_full_pending();
    test_drain_level();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
